inv_key_schedule: RTL and testbench

Iterative AES-128 inverse key expansion for the decryption datapath. It loads the final round key (round 10) and emits round keys 10, 9, … 0 in that order, one per accepted handshake, which is the order the inverse cipher consumes them. Each step reverses one forward expansion step using a single shared AES_Sbox instance (32-bit word in, 32-bit word out). The block sits between the key register and the inverse-round datapath.

---
 rtl/inv_key_schedule.sv | 206 ++++++++++++++++++++
 tb/tb_inv_key_schedule.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_schedule.sv
// ============================================================================
// Module   : inv_key_schedule
// Purpose  : Iterative AES-128 inverse key expansion, round key 10 down to 0.
//            Optional round-key buffer is enabled by defining INV_KEY_BUFFER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_sbox (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);
  // Byte b of the forward S-box sits at bits [(255-b)*8 +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign out_word[8*i +: 8] = SBOX_TABLE[(255 - int'(in_word[8*i +: 8]))*8 +: 8];
  end
endmodule

module inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         start_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         done
`ifdef INV_KEY_BUFFER_EN
  ,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data,
  output logic         buf_full
`endif
);

  if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
    $error("inv_key_schedule supports only NUM_ROUNDS = 10");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic [31:0]    w0_n, w1_n, w2_n, w3_n;
  logic [31:0]    sbox_in, sbox_out;
  logic [7:0]     rc;
  logic           accept;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Undo one forward step: later words first, then w0 through the S-box.
  always_comb begin
    w3_n    = key_q[31:0]  ^ key_q[63:32];
    w2_n    = key_q[63:32] ^ key_q[95:64];
    w1_n    = key_q[95:64] ^ key_q[127:96];
    sbox_in = {w3_n[23:0], w3_n[31:24]};
    rc      = rcon(round_q);
    w0_n    = key_q[127:96] ^ sbox_out ^ {rc, 24'h000000};
  end

  aes_sbox u_sbox (
    .in_word  (sbox_in),
    .out_word (sbox_out)
  );

  assign accept = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = 4'd10;
          valid_d = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (accept) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d   = {w0_n, w1_n, w2_n, w3_n};
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign out_valid   = valid_q;
  assign out_key     = key_q;
  assign out_round   = round_q;
  assign done        = done_q;

`ifdef INV_KEY_BUFFER_EN
  logic [127:0] buf_q [0:10];
  logic [127:0] buf_d [0:10];
  logic         buf_full_q, buf_full_d;

  always_comb begin
    for (int i = 0; i <= 10; i++) begin
      buf_d[i] = buf_q[i];
    end
    buf_full_d = buf_full_q;
    if (state_q == IDLE && start) begin
      buf_full_d = 1'b0;
    end
    if (state_q == EMIT && accept && round_q <= 4'd10) begin
      buf_d[round_q] = key_q;
      if (round_q == 4'd0) begin
        buf_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= 10; i++) begin
        buf_q[i] <= '0;
      end
      buf_full_q <= 1'b0;
    end else begin
      for (int i = 0; i <= 10; i++) begin
        buf_q[i] <= buf_d[i];
      end
      buf_full_q <= buf_full_d;
    end
  end

  assign rk_rd_data = (rk_rd_addr <= 4'd10) ? buf_q[rk_rd_addr] : '0;
  assign buf_full   = buf_full_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
// ============================================================================
// Module   : tb_inv_key_schedule
// Purpose  : Directed self-checking bench for inv_key_schedule (FIPS-197 A.1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         start_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         done;
`ifdef INV_KEY_BUFFER_EN
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;
  logic         buf_full;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [127:0] exp_keys [0:10];

  always #5 clk = ~clk;

  inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key_in      (key_in),
    .start_ready (start_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_key     (out_key),
    .out_round   (out_round),
    .done        (done)
`ifdef INV_KEY_BUFFER_EN
    ,
    .rk_rd_addr  (rk_rd_addr),
    .rk_rd_data  (rk_rd_data),
    .buf_full    (buf_full)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Assumes the start request has just been captured (round 10 on display)
  // and out_ready is high; walks rounds 9..0 and the done pulse.
  task automatic check_rest_of_sequence(input string tag);
    for (int r = 9; r >= 0; r--) begin
      step();
      check($sformatf("%s_round%0d", tag, r), {124'd0, out_round}, 128'(r));
      check($sformatf("%s_key%0d", tag, r), out_key, exp_keys[r]);
      check($sformatf("%s_valid%0d", tag, r), {127'd0, out_valid}, 128'd1);
    end
    step();
    check({tag, "_done"}, {127'd0, done}, 128'd1);
    check({tag, "_ready_back"}, {127'd0, start_ready}, 128'd1);
    check({tag, "_valid_low"}, {127'd0, out_valid}, 128'd0);
    step();
    check({tag, "_done_one_cycle"}, {127'd0, done}, 128'd0);
  endtask

  initial begin
    exp_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset     = 1'b1;
    start     = 1'b0;
    key_in    = '0;
    out_ready = 1'b0;
`ifdef INV_KEY_BUFFER_EN
    rk_rd_addr = 4'd0;
`endif

    // Test 1: reset state
    step();
    step();
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    check("rst_key", out_key, 128'd0);
    check("rst_round", {124'd0, out_round}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_start_ready", {127'd0, start_ready}, 128'd1);
    reset = 1'b0;
    step();
    check("idle_valid", {127'd0, out_valid}, 128'd0);

    // Test 2: full FIPS-197 sequence with out_ready high
    start     = 1'b1;
    key_in    = exp_keys[10];
    out_ready = 1'b1;
    step();
    start = 1'b0;
    check("t2_round10", {124'd0, out_round}, 128'd10);
    check("t2_key10", out_key, exp_keys[10]);
    check("t2_valid10", {127'd0, out_valid}, 128'd1);
    check("t2_not_ready", {127'd0, start_ready}, 128'd0);
    check_rest_of_sequence("t2");

`ifdef INV_KEY_BUFFER_EN
    // Test 6: buffer readback
    rk_rd_addr = 4'd10;
    #1;
    check("buf_rd10", rk_rd_data, exp_keys[10]);
    rk_rd_addr = 4'd0;
    #1;
    check("buf_rd0", rk_rd_data, exp_keys[0]);
    rk_rd_addr = 4'd5;
    #1;
    check("buf_rd5", rk_rd_data, exp_keys[5]);
    rk_rd_addr = 4'd12;
    #1;
    check("buf_rd12", rk_rd_data, 128'd0);
    check("buf_full", {127'd0, buf_full}, 128'd1);
`endif

    // Test 3: three-cycle stall at round 5
    start  = 1'b1;
    key_in = exp_keys[10];
    step();
    start = 1'b0;
    check("t3_round10", {124'd0, out_round}, 128'd10);
    for (int r = 9; r >= 5; r--) begin
      step();
    end
    check("t3_at_round5", {124'd0, out_round}, 128'd5);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("t3_stall%0d_round", s), {124'd0, out_round}, 128'd5);
      check($sformatf("t3_stall%0d_key", s), out_key, exp_keys[5]);
      check($sformatf("t3_stall%0d_valid", s), {127'd0, out_valid}, 128'd1);
    end
    out_ready = 1'b1;
    for (int r = 4; r >= 0; r--) begin
      step();
      check($sformatf("t3_round%0d", r), {124'd0, out_round}, 128'(r));
      check($sformatf("t3_key%0d", r), out_key, exp_keys[r]);
    end
    step();
    check("t3_done", {127'd0, done}, 128'd1);
    step();

    // Test 4: start during EMIT is ignored
    start  = 1'b1;
    key_in = exp_keys[10];
    step();
    key_in = 128'h00112233445566778899aabbccddeeff;
    for (int r = 9; r >= 0; r--) begin
      step();
      check($sformatf("t4_key%0d", r), out_key, exp_keys[r]);
      check($sformatf("t4_ready%0d", r), {127'd0, start_ready}, 128'd0);
    end
    start = 1'b0;
    step();
    check("t4_done", {127'd0, done}, 128'd1);
    step();

    // Test 5: reset mid-sequence at round 6, held with start to show priority
    start  = 1'b1;
    key_in = exp_keys[10];
    step();
    start = 1'b0;
    for (int r = 9; r >= 6; r--) begin
      step();
    end
    check("t5_at_round6", {124'd0, out_round}, 128'd6);
    reset = 1'b1;
    start = 1'b1;
    step();
    check("t5_rst_valid", {127'd0, out_valid}, 128'd0);
    check("t5_rst_done", {127'd0, done}, 128'd0);
    check("t5_rst_round", {124'd0, out_round}, 128'd0);
    check("t5_rst_start_ready", {127'd0, start_ready}, 128'd1);
    reset = 1'b0;
    start = 1'b0;
    step();
    check("t5_no_done_a", {127'd0, done}, 128'd0);
    step();
    check("t5_no_done_b", {127'd0, done}, 128'd0);
    start  = 1'b1;
    key_in = exp_keys[10];
    step();
    start = 1'b0;
    check("t5_round10", {124'd0, out_round}, 128'd10);
    check("t5_key10", out_key, exp_keys[10]);
    check_rest_of_sequence("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
